// File: rtl/clause_bin_ctrl.sv
// Clause-bin sequencer: loads one bin of clause rows from a stream (clearing unused rows)
// and reads a bin back out onto an update stream, skipping empty rows.
module clause_bin_ctrl #(
  parameter int NUM_VARS    = 8,
  parameter int NUM_CLAUSES = 8,
  parameter int WIDTH_C_LEN = 4,
  parameter int WIDTH_CIDX  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start_load_i,
  input  logic                             start_update_i,
  output logic                             busy_o,
  output logic                             done_o,
  input  logic [WIDTH_CIDX:0]              ld_cnt_i,
  input  logic                             ld_valid_i,
  output logic                             ld_ready_o,
  input  logic [NUM_VARS*2-1:0]            ld_clause_i,
  input  logic [WIDTH_C_LEN-1:0]           ld_len_i,
  output logic [NUM_CLAUSES-1:0]           wr_o,
  output logic [NUM_CLAUSES-1:0]           rd_o,
  output logic [NUM_VARS*2-1:0]            clause_o,
  output logic [WIDTH_C_LEN-1:0]           clause_len_o,
  input  logic [NUM_VARS*2-1:0]            clause_i,
  input  logic [WIDTH_C_LEN*NUM_CLAUSES-1:0] clause_len_i,
  output logic                             up_valid_o,
  input  logic                             up_ready_i,
  output logic [NUM_VARS*2-1:0]            up_clause_o,
  output logic [WIDTH_C_LEN-1:0]           up_len_o,
  output logic [WIDTH_CIDX-1:0]            up_idx_o
);

  localparam int CNT_W = WIDTH_CIDX + 1;
  localparam logic [CNT_W-1:0] ROWS = CNT_W'(NUM_CLAUSES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLAUSES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CLEAR,
    S_RD,
    S_OUT,
    S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         idx_q, idx_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [NUM_CLAUSES-1:0]   wr_q, wr_d;
  logic [NUM_VARS*2-1:0]    clause_q, clause_d;
  logic [WIDTH_C_LEN-1:0]   clause_len_q, clause_len_d;
  logic [NUM_VARS*2-1:0]    up_clause_q, up_clause_d;
  logic [WIDTH_C_LEN-1:0]   up_len_q, up_len_d;
  logic [NUM_CLAUSES-1:0]   row_onehot;
  logic [WIDTH_C_LEN-1:0]   row_len;

  assign row_onehot = NUM_CLAUSES'(1) << idx_q[WIDTH_CIDX-1:0];
  assign row_len    = clause_len_i[idx_q[WIDTH_CIDX-1:0]*WIDTH_C_LEN +: WIDTH_C_LEN];

  // idx runs one past the last row in LOAD/CLEAR so the final write is visible before moving on
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    wr_d         = '0;
    clause_d     = clause_q;
    clause_len_d = clause_len_q;
    up_clause_d  = up_clause_q;
    up_len_d     = up_len_q;
    case (state_q)
      S_IDLE: begin
        if (start_load_i) begin
          state_d = S_LOAD;
          idx_d   = '0;
          cnt_d   = (ld_cnt_i > ROWS) ? ROWS : ld_cnt_i;
        end else if (start_update_i) begin
          state_d = S_RD;
          idx_d   = '0;
        end
      end
      S_LOAD: begin
        if (idx_q == cnt_q) begin
          state_d = S_CLEAR;
        end else if (ld_valid_i) begin
          wr_d         = row_onehot;
          clause_d     = ld_clause_i;
          clause_len_d = ld_len_i;
          idx_d        = idx_q + ONE;
        end
      end
      S_CLEAR: begin
        if (idx_q == ROWS) begin
          state_d = S_DONE;
        end else begin
          wr_d         = row_onehot;
          clause_d     = '0;
          clause_len_d = '0;
          idx_d        = idx_q + ONE;
        end
      end
      S_RD: begin
        up_clause_d = clause_i;
        up_len_d    = row_len;
        if (clause_i != '0) begin
          state_d = S_OUT;
        end else if (idx_q == LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + ONE;
        end
      end
      S_OUT: begin
        if (up_ready_i) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            idx_d   = idx_q + ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      wr_q         <= '0;
      clause_q     <= '0;
      clause_len_q <= '0;
      up_clause_q  <= '0;
      up_len_q     <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      clause_q     <= clause_d;
      clause_len_q <= clause_len_d;
      up_clause_q  <= up_clause_d;
      up_len_q     <= up_len_d;
    end
  end

  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign ld_ready_o   = (state_q == S_LOAD) && (idx_q < cnt_q);
  assign wr_o         = wr_q;
  assign clause_o     = clause_q;
  assign clause_len_o = clause_len_q;
  assign rd_o         = (state_q == S_RD) ? row_onehot : '0;
  assign up_valid_o   = (state_q == S_OUT);
  assign up_clause_o  = up_clause_q;
  assign up_len_o     = up_len_q;
  assign up_idx_o     = idx_q[WIDTH_CIDX-1:0];

endmodule

// File: tb/tb_clause_bin_ctrl.sv
// Directed bench for clause_bin_ctrl: per-cycle vector table for a basic load, plus
// load/update/reset sequences checked against a small clause-array model.
module tb_clause_bin_ctrl;

  logic        clk;
  logic        rst;
  logic        start_load_i;
  logic        start_update_i;
  logic        busy_o;
  logic        done_o;
  logic [3:0]  ld_cnt_i;
  logic        ld_valid_i;
  logic        ld_ready_o;
  logic [15:0] ld_clause_i;
  logic [3:0]  ld_len_i;
  logic [7:0]  wr_o;
  logic [7:0]  rd_o;
  logic [15:0] clause_o;
  logic [3:0]  clause_len_o;
  logic [15:0] clause_i;
  logic [31:0] clause_len_i;
  logic        up_valid_o;
  logic        up_ready_i;
  logic [15:0] up_clause_o;
  logic [3:0]  up_len_o;
  logic [2:0]  up_idx_o;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [15:0] memC [8];
  logic [3:0]  memL [8];

  clause_bin_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start_load_i   (start_load_i),
    .start_update_i (start_update_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ld_cnt_i       (ld_cnt_i),
    .ld_valid_i     (ld_valid_i),
    .ld_ready_o     (ld_ready_o),
    .ld_clause_i    (ld_clause_i),
    .ld_len_i       (ld_len_i),
    .wr_o           (wr_o),
    .rd_o           (rd_o),
    .clause_o       (clause_o),
    .clause_len_o   (clause_len_o),
    .clause_i       (clause_i),
    .clause_len_i   (clause_len_i),
    .up_valid_o     (up_valid_o),
    .up_ready_i     (up_ready_i),
    .up_clause_o    (up_clause_o),
    .up_len_o       (up_len_o),
    .up_idx_o       (up_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clause array model: read data follows the one-hot row select combinationally
  always_comb begin
    clause_i     = '0;
    clause_len_i = '0;
    for (int i = 0; i < 8; i++) begin
      clause_len_i[i*4 +: 4] = memL[i];
      if (rd_o[i]) clause_i = memC[i];
    end
  end

  typedef struct {
    logic        start;
    logic        valid;
    logic [15:0] clause;
    logic [3:0]  len;
    logic [7:0]  expWr;
    logic [15:0] expClause;
    logic [3:0]  expLen;
    logic        expReady;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [15:0] patClause(input int k);
    return 16'(32'h5A01 + k * 17);
  endfunction

  function automatic logic [3:0] patLen(input int k);
    return 4'(k + 9);
  endfunction

  function automatic logic [7:0] rowBit(input int k);
    logic [7:0] one;
    one = 8'd1;
    return (k < 8) ? (one << k) : 8'd0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start_load_i   = v.start;
    start_update_i = 1'b0;
    ld_valid_i     = v.valid;
    ld_clause_i    = v.clause;
    ld_len_i       = v.len;
  endtask

  task automatic idleInputs();
    start_load_i   = 1'b0;
    start_update_i = 1'b0;
    ld_valid_i     = 1'b0;
    ld_clause_i    = '0;
    ld_len_i       = '0;
    up_ready_i     = 1'b0;
  endtask

  // Runs one load; counts writes, checks row order and data, and the cycle done_o appears
  task automatic doLoad(input int cnt, input bit gapped, input bit bothStart,
                        input bit pokeBusy, input int expDoneCyc);
    int eff, sent, nWr, doneCyc;
    bit readySeen, rdSeen;
    eff = (cnt > 8) ? 8 : cnt;
    sent = 0; nWr = 0; doneCyc = -1; readySeen = 0; rdSeen = 0;
    for (int c = 0; c < 60 && doneCyc < 0; c++) begin
      @(negedge clk);
      start_load_i   = (c == 0) || (pokeBusy && c == 5);
      start_update_i = (c == 0 && bothStart) || (pokeBusy && c == 6);
      ld_cnt_i       = (c == 0) ? 4'(cnt) : 4'd2;
      ld_valid_i     = gapped ? (c % 2 == 1) : 1'b1;
      ld_clause_i    = patClause(sent);
      ld_len_i       = patLen(sent);
      #1;
      if (ld_ready_o) readySeen = 1;
      if (rd_o != 8'd0) rdSeen = 1;
      if (wr_o != 8'd0) begin
        checkOutput("ld_wr_row", 32'(wr_o), 32'(rowBit(nWr)));
        checkOutput("ld_wr_clause", 32'(clause_o), (nWr < eff) ? 32'(patClause(nWr)) : 32'd0);
        checkOutput("ld_wr_len", 32'(clause_len_o), (nWr < eff) ? 32'(patLen(nWr)) : 32'd0);
        nWr++;
      end
      if (ld_ready_o && ld_valid_i) sent++;
      if (done_o) doneCyc = c;
    end
    checkOutput("ld_done_seen", 32'(doneCyc >= 0), 32'd1);
    checkOutput("ld_write_count", 32'(nWr), 32'd8);
    checkOutput("ld_accepted", 32'(sent), 32'(eff));
    checkOutput("ld_ready_seen", 32'(readySeen), 32'(eff > 0));
    checkOutput("ld_no_rd", 32'(rdSeen), 32'd0);
    if (expDoneCyc >= 0) checkOutput("ld_done_cycle", 32'(doneCyc), 32'(expDoneCyc));
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("ld_busy_after_done", 32'(busy_o), 32'd0);
    checkOutput("ld_done_one_cycle", 32'(done_o), 32'd0);
  endtask

  // Runs one readback against memC/memL; each beat stalled stallCyc cycles before accept
  task automatic doUpdate(input int stallCyc);
    int expIdx [8];
    int nExp, nBeats, stall, doneCyc;
    logic [15:0] heldC;
    logic [3:0]  heldL;
    logic [2:0]  heldI;
    nExp = 0; nBeats = 0; stall = 0; doneCyc = -1;
    heldC = '0; heldL = '0; heldI = '0;
    for (int i = 0; i < 8; i++) begin
      if (memC[i] != 16'd0) begin
        expIdx[nExp] = i;
        nExp++;
      end
    end
    for (int c = 0; c < 100 && doneCyc < 0; c++) begin
      @(negedge clk);
      start_update_i = (c == 0);
      up_ready_i     = (stall >= stallCyc);
      #1;
      if (up_valid_o) begin
        checkOutput("up_rd_idle", 32'(rd_o), 32'd0);
        if (stall == 0) begin
          if (nBeats < nExp) begin
            checkOutput("up_idx", 32'(up_idx_o), 32'(expIdx[nBeats]));
            checkOutput("up_clause", 32'(up_clause_o), 32'(memC[expIdx[nBeats]]));
            checkOutput("up_len", 32'(up_len_o), 32'(memL[expIdx[nBeats]]));
          end else begin
            checkOutput("up_extra_beat", 32'(nBeats), 32'(nExp));
          end
          heldC = up_clause_o; heldL = up_len_o; heldI = up_idx_o;
        end else begin
          checkOutput("up_stall_stable", {9'd0, up_idx_o, up_len_o, up_clause_o},
                      {9'd0, heldI, heldL, heldC});
        end
        if (up_ready_i) begin
          nBeats++;
          stall = 0;
        end else begin
          stall++;
        end
      end
      if (done_o) doneCyc = c;
    end
    checkOutput("up_done_seen", 32'(doneCyc >= 0), 32'd1);
    checkOutput("up_beat_count", 32'(nBeats), 32'(nExp));
    @(negedge clk);
    idleInputs();
    #1;
    checkOutput("up_busy_after_done", 32'(busy_o), 32'd0);
  endtask

  initial begin
    bit sawSecond;
    rst = 1'b1;
    ld_cnt_i = 4'd0;
    idleInputs();
    for (int i = 0; i < 8; i++) begin
      memC[i] = '0;
      memL[i] = '0;
    end

    // Per-cycle vectors: load 3 clauses with ld_valid held high; cycle 0 carries the start pulse
    vecs[0]  = '{1'b1, 1'b1, 16'h1111, 4'd3,  8'h00, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 16'hA1C3, 4'd3,  8'h00, 16'h0000, 4'd0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 16'hB2D4, 4'd5,  8'h01, 16'hA1C3, 4'd3, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 16'hC3E5, 4'd7,  8'h02, 16'hB2D4, 4'd5, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h04, 16'hC3E5, 4'd7, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h00, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h08, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h10, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h20, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h40, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 16'hFFFF, 4'd15, 8'h80, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'h0000, 4'd0,  8'h00, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b0, 16'h0000, 4'd0,  8'h00, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_done", 32'(done_o), 32'd0);
    checkOutput("rst_wr", 32'(wr_o), 32'd0);
    checkOutput("rst_rd", 32'(rd_o), 32'd0);
    checkOutput("rst_ready", 32'(ld_ready_o), 32'd0);
    checkOutput("rst_up_valid", 32'(up_valid_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] table-driven load, cnt=3");
    ld_cnt_i = 4'd3;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput("tbl_wr", 32'(wr_o), 32'(vecs[i].expWr));
      checkOutput("tbl_ready", 32'(ld_ready_o), 32'(vecs[i].expReady));
      checkOutput("tbl_busy", 32'(busy_o), 32'(vecs[i].expBusy));
      checkOutput("tbl_done", 32'(done_o), 32'(vecs[i].expDone));
      checkOutput("tbl_rd", 32'(rd_o), 32'd0);
      if (vecs[i].expWr != 8'd0) begin
        checkOutput("tbl_clause", 32'(clause_o), 32'(vecs[i].expClause));
        checkOutput("tbl_len", 32'(clause_len_o), 32'(vecs[i].expLen));
      end
    end
    idleInputs();

    $display("[TB] gapped load, cnt=3");
    doLoad(3, 1'b1, 1'b0, 1'b0, -1);
    $display("[TB] oversize load, cnt=9");
    doLoad(9, 1'b0, 1'b0, 1'b0, 11);
    $display("[TB] empty load, cnt=0");
    doLoad(0, 1'b0, 1'b0, 1'b0, 11);
    $display("[TB] simultaneous starts and starts while busy");
    doLoad(3, 1'b0, 1'b1, 1'b1, 11);

    $display("[TB] update, rows 0 and 5 populated, stalled beats");
    for (int i = 0; i < 8; i++) begin
      memC[i] = 16'h0000;
      memL[i] = 4'd2;
    end
    memC[0] = 16'h0009; memL[0] = 4'd4;
    memC[5] = 16'h6000; memL[5] = 4'd0;
    doUpdate(3);

    $display("[TB] update, only last row populated");
    for (int i = 0; i < 8; i++) begin
      memC[i] = 16'h0000;
      memL[i] = 4'd1;
    end
    memC[7] = 16'h8001; memL[7] = 4'd9;
    doUpdate(0);

    $display("[TB] reset in the middle of a load");
    sawSecond = 0;
    for (int c = 0; c < 20 && !sawSecond; c++) begin
      @(negedge clk);
      start_load_i = (c == 0);
      ld_cnt_i     = 4'd3;
      ld_valid_i   = 1'b1;
      ld_clause_i  = 16'h7777;
      ld_len_i     = 4'd6;
      #1;
      if (wr_o == 8'h02) sawSecond = 1;
    end
    checkOutput("rst_mid_second_write", 32'(sawSecond), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_mid_wr", 32'(wr_o), 32'd0);
    checkOutput("rst_mid_busy", 32'(busy_o), 32'd0);
    checkOutput("rst_mid_ready", 32'(ld_ready_o), 32'd0);
    checkOutput("rst_mid_clause", 32'(clause_o), 32'd0);
    @(negedge clk);
    idleInputs();
    rst = 1'b0;
    doLoad(2, 1'b0, 1'b0, 1'b0, 11);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
